// File: rtl/hex_display_ctrl.sv
// ---------------------------------------------------------------------------
// hex_display_ctrl
//   Drives NUM_DIGITS common-anode seven-segment digits from a captured set of
//   hex nibbles, decimal points and blink enables. A single-cycle load strobe
//   captures the inputs into shadow registers; the registered segment outputs
//   follow one edge later. Leading-zero blanking is applied live from blank_lz.
//
//   Optional feature macro: HEX_DISPLAY_BLINK_EN
//     defined   -> blink prescaler and blink_phase are built; digits whose
//                  captured blink_mask bit is set go blank while blink_phase=1
//     undefined -> blink_mask is ignored and no prescaler exists
//
// Ports
//   Clk        in   system clock, rising edge
//   Reset_n    in   asynchronous active-low reset
//   load       in   capture strobe for value/dp/blink_mask
//   value      in   4*NUM_DIGITS hex nibbles, nibble i -> digit i (0 = LSD)
//   dp         in   NUM_DIGITS decimal-point enables
//   blink_mask in   NUM_DIGITS blink enables
//   blank_lz   in   leading-zero blanking enable (sampled live)
//   load_ack   out  one-cycle pulse after each capture edge
//   hex_out    out  8*NUM_DIGITS active-low segments, byte i = digit i,
//                   bit 7 = DP, bits 6:0 = g..a
// ---------------------------------------------------------------------------
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    blank_lz,
  output logic                    load_ack,
  output logic [8*NUM_DIGITS-1:0] hex_out
);

  // Active-low segment pattern (bit 7 = DP off) for one nibble.
  function automatic logic [7:0] seg_encode(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

  logic [4*NUM_DIGITS-1:0] r_value;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic                    r_shown;
  logic                    r_load_ack;
  logic [8*NUM_DIGITS-1:0] r_hex;
  logic [NUM_DIGITS-1:0]   w_lz;
  logic [NUM_DIGITS-1:0]   w_blink_off;
  logic [8*NUM_DIGITS-1:0] w_hex_nxt;

  // Shadow capture; reset discards anything captured but not yet shown.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_value    <= '0;
      r_dp       <= '0;
      r_shown    <= 1'b0;
      r_load_ack <= 1'b0;
    end else begin
      r_load_ack <= load;
      if (load) begin
        r_value <= value;
        r_dp    <= dp;
        r_shown <= 1'b1;
      end
    end
  end

`ifdef HEX_DISPLAY_BLINK_EN
  localparam int PW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(BLINK_DIV - 1);

  logic [NUM_DIGITS-1:0] r_blink;
  logic [PW-1:0]         r_presc;
  logic                  r_blink_phase;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_blink <= '0;
    end else if (load) begin
      r_blink <= blink_mask;
    end
  end

  // Free-running: load never disturbs the blink cadence.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_presc       <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_presc == PRESC_TC) begin
      r_presc       <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  assign w_blink_off = r_blink_phase ? r_blink : '0;
`else
  logic w_unused_blink;
  assign w_unused_blink = ^blink_mask;
  assign w_blink_off    = '0;
`endif

  // Leading-zero chain from the MSD down; digit 0 is never blanked, and a
  // blinking digit is judged on its captured nibble, not its display state.
  always_comb begin
    w_lz = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (blank_lz && (r_value[4*i +: 4] == 4'h0) && !r_dp[i] &&
          ((i == NUM_DIGITS - 1) || w_lz[(i + 1) % NUM_DIGITS])) begin
        w_lz[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_hex_nxt = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_shown && !w_lz[i] && !w_blink_off[i]) begin
        w_hex_nxt[8*i +: 8] = seg_encode(r_value[4*i +: 4]) & {~r_dp[i], 7'h7F};
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_hex <= '1;
    end else begin
      r_hex <= w_hex_nxt;
    end
  end

  assign load_ack = r_load_ack;
  assign hex_out  = r_hex;

endmodule
